ray_config_multi: RTL and testbench
===================================

# ray_config_multi

Memory-mapped configuration and control slave for a ray-tracer array of NUM_CORES cores. It sits on the MemoryBus slave side and holds the shared scene registers: material, tree and frame base addresses, camera Q/V/X/Y vectors and frame size. It also holds per-core row-band assignments, per-core and broadcast start, done detection with a maskable write-1-to-clear interrupt, and a completion counter. Reads are answered through a single response slot that accepts back-to-back requests.

## Interface
- NUM_CORES, 4: core count, 1..16.
- POSITION_WIDTH, 16: camera component width.
- DATA_WIDTH, 24: bus data width.
- ADDRESS_WIDTH, 32: bus address width.
- ADDRESS, 0: window tag compared with msAddress[ADDRESS_WIDTH-1:BASE_WIDTH].
- BASE_WIDTH, 6: offset width. Elaboration error if NUM_CORES > 16.
- clock  in  1  sole clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- materialAddress, treeAddress, frameAddress  out  ADDRESS_WIDTH each  {written 24 bits, 8'b0}.
- cameraQ[2:0] (unsigned), cameraV/X/Y[2:0] (signed)  out  POSITION_WIDTH each.
- width, height  out  12 each.
- rowStart[NUM_CORES], rowEnd[NUM_CORES]  out  12 each  core row band, end exclusive.
- start  out  NUM_CORES  one-cycle start pulse per core.
- ready, busy  in  NUM_CORES  per-core status.
- flush  out  1  one-cycle pulse.
- resetRT  out  1  pulse, OR'd with !resetN.
- normalize  out  1  level.
- interrupt  out  1  |(irqStatus & irqMask), registered.
- bus  MemoryBus.Slave  msValid/msTaken/msWrite/msAddress/msData/msID, smValid/smTaken/smData/smID.

## Operation
- Hit = tag match && msValid. msTaken = hit && (!respValid || (smValid && smTaken)).
- Writes produce no response. Reads load smData/smID and set respValid.
- Global offsets:
  - 0x00 CTRL write: bit0 startAll (start pulse to every core with enable set), bit3 flush, bit4 resetRT, bit5 normalize (stored). Read: {normalize,2'b0,|busy,&ready,1'b0}.
  - 0x01-0x03: material/tree/frame address.
  - 0x04-0x0F: Q0..2, V0..2, X0..2, Y0..2, truncated to POSITION_WIDTH. Reads sign- or zero-extend to match signedness.
  - 0x10/0x11: width/height.
  - 0x12 coreEnable, NUM_CORES bits.
  - 0x13 irqStatus: write-1-to-clear.
  - 0x14 irqMask.
  - 0x15 doneCount: 24-bit, saturating; any write clears it.
- Per-core offsets, core c:
  - 0x20+2c band: data[11:0] is rowStart, data[23:12] is rowEnd.
  - 0x21+2c: write bit0 starts core c regardless of enable. Read returns {busy[c],ready[c]}.
- Unmapped offsets, or core index >= NUM_CORES: write ignored, read returns 0 and still responds.
- Done event for core c: busy[c] registered 1, now 0. The event sets irqStatus[c] and increments doneCount by the popcount of events, saturating at 2^24-1.
- Set and W1C on the same bit in the same cycle: set wins.
- Clear and event on doneCount in the same cycle: result is the event count.

## Timing
- Reset values:
  - Addresses, camera, width, height, rows, irqStatus, irqMask, doneCount, normalize: 0.
  - coreEnable: all ones.
  - start, flush: 0.
  - resetRT: 1 while resetN is low.
  - respValid, interrupt: 0.
- Write takes effect on the accept edge. Outputs are visible the next cycle.
- start, flush and the registered resetRT pulse are high for exactly the cycle after the accept.
- startAll and a per-core start on the same core in one cycle give a single pulse.
- Read latency: smValid in the cycle after accept. It holds, with stable smData/smID, until smTaken.
- Sustained read throughput is 1 per cycle when smTaken is held high.
- Read status values are sampled at the accept edge.
- interrupt lags its status/mask change by 1 cycle.
- resetN asserted mid-transaction drops respValid immediately. No response is delivered.

## Structure
- ray_config_pkg: offset constants (CTRL, MATERIAL, …, CORE_BASE=0x20), CTRL bit indices, MAX_CORES=16.
- Sub-module ray_done_tracker, one instance per core: busy edge detect, irqStatus bit with set-wins W1C, event output.

## Test plan
- Reset, then read 0x12 with NUM_CORES=4 → 0x00000F. Read 0x00 with ready=4'hF, busy=0 → 0x000002.
- Write 0x04=0x12345, then read → cameraQ[0]=0x2345, returns 0x002345. Write 0x07=0xFFFF → V0=-1, read returns 0xFFFFFF.
- coreEnable=4'b0101, write CTRL=0x1 → start=4'b0101 for one cycle only. Write 0x23 bit0 → start=4'b0010.
- Drop busy on cores 0 and 2 in the same cycle with mask=0x5 → irqStatus=0x5, doneCount=2, interrupt high a cycle later. Write 0x13=0x1 while core 0 falls again → status bit 0 stays 1.
- Issue four back-to-back reads with smTaken tied 1 → 4 responses in consecutive cycles with matching IDs. With smTaken=0, the second read is not taken until the first is sent.
- Read offset 0x3F with NUM_CORES=4 → response 0. Pulse resetN low during a pending response → smValid=0 immediately and all registers return to reset values.

Source files
------------

// File: rtl/ray_config_pkg.sv
// Shared register map and field positions for the ray-tracer configuration slave.
package ray_config_pkg;

    localparam int MAX_CORES        = 16;
    localparam int NUM_CAMERA_REGS  = 12;
    localparam int ROW_WIDTH        = 12;
    localparam int DONE_COUNT_WIDTH = 24;

    localparam logic [7:0] OFF_CTRL        = 8'h00;
    localparam logic [7:0] OFF_MATERIAL    = 8'h01;
    localparam logic [7:0] OFF_TREE        = 8'h02;
    localparam logic [7:0] OFF_FRAME       = 8'h03;
    localparam logic [7:0] OFF_CAMERA      = 8'h04;
    localparam logic [7:0] OFF_WIDTH       = 8'h10;
    localparam logic [7:0] OFF_HEIGHT      = 8'h11;
    localparam logic [7:0] OFF_CORE_ENABLE = 8'h12;
    localparam logic [7:0] OFF_IRQ_STATUS  = 8'h13;
    localparam logic [7:0] OFF_IRQ_MASK    = 8'h14;
    localparam logic [7:0] OFF_DONE_COUNT  = 8'h15;
    localparam logic [7:0] OFF_CORE_BASE   = 8'h20;

    localparam int CTRL_START_ALL = 0;
    localparam int CTRL_FLUSH     = 3;
    localparam int CTRL_RESET_RT  = 4;
    localparam int CTRL_NORMALIZE = 5;

endpackage

// File: rtl/ray_done_tracker.sv
// Per-core completion tracker: detects busy falling and keeps a sticky
// interrupt status bit that software clears by writing a one.
module ray_done_tracker (
    input  logic clock,
    input  logic resetN,
    input  logic busy,
    input  logic clear,
    output logic status,
    output logic done_event
);

    logic busy_q, busy_d;
    logic status_q, status_d;

    always_comb begin
        busy_d     = busy;
        done_event = busy_q & ~busy;
        // A completion landing in the same cycle as a clear must not be lost.
        status_d   = done_event | (status_q & ~clear);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            busy_q   <= 1'b0;
            status_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            status_q <= status_d;
        end
    end

    assign status = status_q;

endmodule

// File: rtl/ray_config_multi.sv
// Memory-mapped scene/camera configuration and per-core control for the
// ray-tracer array, with a single read response slot on the slave bus.
module ray_config_multi
    import ray_config_pkg::*;
#(
    parameter int NUM_CORES      = 4,
    parameter int POSITION_WIDTH = 16,
    parameter int DATA_WIDTH     = 24,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int ADDRESS        = 0,
    parameter int BASE_WIDTH     = 6,
    parameter int ID_WIDTH       = 4
) (
    input  logic                             clock,
    input  logic                             resetN,
    output logic [ADDRESS_WIDTH-1:0]         materialAddress,
    output logic [ADDRESS_WIDTH-1:0]         treeAddress,
    output logic [ADDRESS_WIDTH-1:0]         frameAddress,
    output logic [POSITION_WIDTH-1:0]        cameraQ [3],
    output logic signed [POSITION_WIDTH-1:0] cameraV [3],
    output logic signed [POSITION_WIDTH-1:0] cameraX [3],
    output logic signed [POSITION_WIDTH-1:0] cameraY [3],
    output logic [ROW_WIDTH-1:0]             width,
    output logic [ROW_WIDTH-1:0]             height,
    output logic [ROW_WIDTH-1:0]             rowStart [NUM_CORES],
    output logic [ROW_WIDTH-1:0]             rowEnd [NUM_CORES],
    output logic [NUM_CORES-1:0]             start,
    input  logic [NUM_CORES-1:0]             ready,
    input  logic [NUM_CORES-1:0]             busy,
    output logic                             flush,
    output logic                             resetRT,
    output logic                             normalize,
    output logic                             interrupt,
    input  logic                             msValid,
    output logic                             msTaken,
    input  logic                             msWrite,
    input  logic [ADDRESS_WIDTH-1:0]         msAddress,
    input  logic [DATA_WIDTH-1:0]            msData,
    input  logic [ID_WIDTH-1:0]              msID,
    output logic                             smValid,
    input  logic                             smTaken,
    output logic [DATA_WIDTH-1:0]            smData,
    output logic [ID_WIDTH-1:0]              smID
);

    if (NUM_CORES < 1 || NUM_CORES > MAX_CORES) begin : g_bad_core_count
        $error("ray_config_multi: NUM_CORES must be in 1..16");
    end

    logic                      hit, wr_en, rd_en;
    logic [7:0]                offset, core_off;
    logic [NUM_CORES-1:0]      core_sel;
    logic [DATA_WIDTH-1:0]     rd_data;

    logic [DATA_WIDTH-1:0]     addr_q [3], addr_d [3];
    logic [POSITION_WIDTH-1:0] cam_q [NUM_CAMERA_REGS], cam_d [NUM_CAMERA_REGS];
    logic [ROW_WIDTH-1:0]      width_q, width_d, height_q, height_d;
    logic [ROW_WIDTH-1:0]      row_start_q [NUM_CORES], row_start_d [NUM_CORES];
    logic [ROW_WIDTH-1:0]      row_end_q [NUM_CORES], row_end_d [NUM_CORES];
    logic [NUM_CORES-1:0]      core_enable_q, core_enable_d, irq_mask_q, irq_mask_d;
    logic [NUM_CORES-1:0]      start_q, start_d, irq_clear, irq_status, done_event;
    logic [DONE_COUNT_WIDTH-1:0] done_count_q, done_count_d;
    logic [DONE_COUNT_WIDTH:0] count_sum;
    logic [4:0]                done_pop;
    logic                      count_clear;
    logic                      normalize_q, normalize_d, flush_q, flush_d;
    logic                      reset_rt_q, reset_rt_d, interrupt_q, interrupt_d;
    logic                      resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]     resp_data_q, resp_data_d;
    logic [ID_WIDTH-1:0]       resp_id_q, resp_id_d;

    assign hit      = msValid && (msAddress[ADDRESS_WIDTH-1:BASE_WIDTH] ==
                                  (ADDRESS_WIDTH-BASE_WIDTH)'(ADDRESS));
    assign msTaken  = hit && (!resp_valid_q || smTaken);
    assign wr_en    = msTaken && msWrite;
    assign rd_en    = msTaken && !msWrite;
    assign offset   = 8'(msAddress[BASE_WIDTH-1:0]);
    assign core_off = offset - OFF_CORE_BASE;

    always_comb begin
        core_sel = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            core_sel[c] = (offset >= OFF_CORE_BASE) && (core_off[7:1] == 7'(c));
        end
    end

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
        ray_done_tracker u_tracker (
            .clock      (clock),
            .resetN     (resetN),
            .busy       (busy[c]),
            .clear      (irq_clear[c]),
            .status     (irq_status[c]),
            .done_event (done_event[c])
        );
    end

    always_comb begin
        addr_d        = addr_q;
        cam_d         = cam_q;
        width_d       = width_q;
        height_d      = height_q;
        row_start_d   = row_start_q;
        row_end_d     = row_end_q;
        core_enable_d = core_enable_q;
        irq_mask_d    = irq_mask_q;
        normalize_d   = normalize_q;
        start_d       = '0;
        flush_d       = 1'b0;
        reset_rt_d    = 1'b0;
        irq_clear     = '0;
        count_clear   = 1'b0;
        if (wr_en) begin
            case (offset)
                OFF_CTRL: begin
                    if (msData[CTRL_START_ALL]) start_d = core_enable_q;
                    flush_d     = msData[CTRL_FLUSH];
                    reset_rt_d  = msData[CTRL_RESET_RT];
                    normalize_d = msData[CTRL_NORMALIZE];
                end
                OFF_MATERIAL:    addr_d[0] = msData;
                OFF_TREE:        addr_d[1] = msData;
                OFF_FRAME:       addr_d[2] = msData;
                OFF_WIDTH:       width_d = msData[ROW_WIDTH-1:0];
                OFF_HEIGHT:      height_d = msData[ROW_WIDTH-1:0];
                OFF_CORE_ENABLE: core_enable_d = msData[NUM_CORES-1:0];
                OFF_IRQ_STATUS:  irq_clear = msData[NUM_CORES-1:0];
                OFF_IRQ_MASK:    irq_mask_d = msData[NUM_CORES-1:0];
                OFF_DONE_COUNT:  count_clear = 1'b1;
                default: ;
            endcase
            for (int i = 0; i < NUM_CAMERA_REGS; i++) begin
                if (offset == OFF_CAMERA + 8'(i)) cam_d[i] = msData[POSITION_WIDTH-1:0];
            end
            // Even per-core offsets hold the row band, odd ones are the start strobe.
            for (int c = 0; c < NUM_CORES; c++) begin
                if (core_sel[c] && !core_off[0]) begin
                    row_start_d[c] = msData[ROW_WIDTH-1:0];
                    row_end_d[c]   = msData[2*ROW_WIDTH-1:ROW_WIDTH];
                end else if (core_sel[c] && msData[0]) begin
                    start_d[c] = 1'b1;
                end
            end
        end
    end

    // A clear in the same cycle as completions leaves just the new completions.
    always_comb begin
        done_pop = '0;
        for (int c = 0; c < NUM_CORES; c++) done_pop = done_pop + 5'(done_event[c]);
        count_sum    = (count_clear ? '0 : {1'b0, done_count_q}) + (DONE_COUNT_WIDTH+1)'(done_pop);
        done_count_d = count_sum[DONE_COUNT_WIDTH] ? '1 : count_sum[DONE_COUNT_WIDTH-1:0];
        interrupt_d  = |(irq_status & irq_mask_q);
    end

    always_comb begin
        rd_data = '0;
        case (offset)
            OFF_CTRL:        rd_data = DATA_WIDTH'({normalize_q, 2'b00, |busy, &ready, 1'b0});
            OFF_MATERIAL:    rd_data = addr_q[0];
            OFF_TREE:        rd_data = addr_q[1];
            OFF_FRAME:       rd_data = addr_q[2];
            OFF_WIDTH:       rd_data = DATA_WIDTH'(width_q);
            OFF_HEIGHT:      rd_data = DATA_WIDTH'(height_q);
            OFF_CORE_ENABLE: rd_data = DATA_WIDTH'(core_enable_q);
            OFF_IRQ_STATUS:  rd_data = DATA_WIDTH'(irq_status);
            OFF_IRQ_MASK:    rd_data = DATA_WIDTH'(irq_mask_q);
            OFF_DONE_COUNT:  rd_data = DATA_WIDTH'(done_count_q);
            default: ;
        endcase
        // Q is unsigned, V/X/Y read back sign-extended.
        for (int i = 0; i < NUM_CAMERA_REGS; i++) begin
            if (offset == OFF_CAMERA + 8'(i)) begin
                rd_data = (i < 3) ? DATA_WIDTH'(cam_q[i])
                                  : {{(DATA_WIDTH-POSITION_WIDTH){cam_q[i][POSITION_WIDTH-1]}}, cam_q[i]};
            end
        end
        for (int c = 0; c < NUM_CORES; c++) begin
            if (core_sel[c]) begin
                rd_data = core_off[0] ? DATA_WIDTH'({busy[c], ready[c]})
                                      : DATA_WIDTH'({row_end_q[c], row_start_q[c]});
            end
        end
    end

    always_comb begin
        resp_valid_d = rd_en | (resp_valid_q & ~smTaken);
        resp_data_d  = rd_en ? rd_data : resp_data_q;
        resp_id_d    = rd_en ? msID : resp_id_q;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            addr_q        <= '{default: '0};
            cam_q         <= '{default: '0};
            width_q       <= '0;
            height_q      <= '0;
            row_start_q   <= '{default: '0};
            row_end_q     <= '{default: '0};
            core_enable_q <= '1;
            irq_mask_q    <= '0;
            done_count_q  <= '0;
            normalize_q   <= 1'b0;
            start_q       <= '0;
            flush_q       <= 1'b0;
            reset_rt_q    <= 1'b0;
            interrupt_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
            resp_id_q     <= '0;
        end else begin
            addr_q        <= addr_d;
            cam_q         <= cam_d;
            width_q       <= width_d;
            height_q      <= height_d;
            row_start_q   <= row_start_d;
            row_end_q     <= row_end_d;
            core_enable_q <= core_enable_d;
            irq_mask_q    <= irq_mask_d;
            done_count_q  <= done_count_d;
            normalize_q   <= normalize_d;
            start_q       <= start_d;
            flush_q       <= flush_d;
            reset_rt_q    <= reset_rt_d;
            interrupt_q   <= interrupt_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            resp_id_q     <= resp_id_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cameraQ[i] = cam_q[i];
            cameraV[i] = cam_q[3+i];
            cameraX[i] = cam_q[6+i];
            cameraY[i] = cam_q[9+i];
        end
    end

    assign materialAddress = {addr_q[0], {(ADDRESS_WIDTH-DATA_WIDTH){1'b0}}};
    assign treeAddress     = {addr_q[1], {(ADDRESS_WIDTH-DATA_WIDTH){1'b0}}};
    assign frameAddress    = {addr_q[2], {(ADDRESS_WIDTH-DATA_WIDTH){1'b0}}};
    assign width           = width_q;
    assign height          = height_q;
    assign rowStart        = row_start_q;
    assign rowEnd          = row_end_q;
    assign start           = start_q;
    assign flush           = flush_q;
    assign resetRT         = reset_rt_q | ~resetN;
    assign normalize       = normalize_q;
    assign interrupt       = interrupt_q;
    assign smValid         = resp_valid_q;
    assign smData          = resp_data_q;
    assign smID            = resp_id_q;

endmodule

// File: tb/tb_ray_config_multi.sv
// Randomized scoreboard bench for ray_config_multi against a register-level
// reference model of the configuration map.
module tb_ray_config_multi;

    localparam int NC = 4;

    logic               clock, resetN;
    logic [31:0]        materialAddress, treeAddress, frameAddress;
    logic [15:0]        cameraQ [3];
    logic signed [15:0] cameraV [3];
    logic signed [15:0] cameraX [3];
    logic signed [15:0] cameraY [3];
    logic [11:0]        width, height;
    logic [11:0]        rowStart [NC];
    logic [11:0]        rowEnd [NC];
    logic [NC-1:0]      start, ready, busy;
    logic               flush, resetRT, normalize, interrupt;
    logic               msValid, msTaken, msWrite;
    logic [31:0]        msAddress;
    logic [23:0]        msData;
    logic [3:0]         msID;
    logic               smValid, smTaken;
    logic [23:0]        smData;
    logic [3:0]         smID;

    ray_config_multi #(.NUM_CORES(NC)) dut (
        .clock(clock), .resetN(resetN),
        .materialAddress(materialAddress), .treeAddress(treeAddress), .frameAddress(frameAddress),
        .cameraQ(cameraQ), .cameraV(cameraV), .cameraX(cameraX), .cameraY(cameraY),
        .width(width), .height(height), .rowStart(rowStart), .rowEnd(rowEnd),
        .start(start), .ready(ready), .busy(busy), .flush(flush), .resetRT(resetRT),
        .normalize(normalize), .interrupt(interrupt),
        .msValid(msValid), .msTaken(msTaken), .msWrite(msWrite), .msAddress(msAddress),
        .msData(msData), .msID(msID),
        .smValid(smValid), .smTaken(smTaken), .smData(smData), .smID(smID)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [23:0] data;
        logic [3:0]  id;
    } resp_t;
    resp_t exp_q[$];

    // Reference model: register contents as software sees them.
    logic [23:0] m_addr [3];
    logic [15:0] m_cam [12];
    logic [11:0] m_width, m_height;
    logic [11:0] m_row_s [NC];
    logic [11:0] m_row_e [NC];
    logic [NC-1:0] m_enable, m_status, m_mask, m_prev_busy;
    int          m_count;
    logic        m_norm, m_resp;
    logic [NC-1:0] exp_start;
    logic        exp_flush, exp_reset_rt, exp_int;

    logic [3:0]  next_id = 4'd0;
    bit          rand_taken = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) m_addr[i] = '0;
        for (int i = 0; i < 12; i++) m_cam[i] = '0;
        for (int c = 0; c < NC; c++) begin
            m_row_s[c] = '0;
            m_row_e[c] = '0;
        end
        m_width = '0; m_height = '0;
        m_enable = '1; m_status = '0; m_mask = '0; m_prev_busy = '0;
        m_count = 0; m_norm = 1'b0; m_resp = 1'b0;
        exp_start = '0; exp_flush = 1'b0; exp_reset_rt = 1'b0; exp_int = 1'b0;
        exp_q.delete();
    endfunction

    function automatic logic [23:0] read_value(input int off);
        int c;
        if (off == 0) return {18'd0, m_norm, 2'b00, |busy, &ready, 1'b0};
        if (off >= 1 && off <= 3) return m_addr[off-1];
        if (off >= 4 && off <= 6) return {8'd0, m_cam[off-4]};
        if (off >= 7 && off <= 15) return {{8{m_cam[off-4][15]}}, m_cam[off-4]};
        if (off == 16) return {12'd0, m_width};
        if (off == 17) return {12'd0, m_height};
        if (off == 18) return 24'(m_enable);
        if (off == 19) return 24'(m_status);
        if (off == 20) return 24'(m_mask);
        if (off == 21) return 24'(m_count);
        if (off >= 32) begin
            c = (off - 32) / 2;
            if (c < NC) begin
                if (off % 2 == 0) return {m_row_e[c], m_row_s[c]};
                return {22'd0, busy[c], ready[c]};
            end
        end
        return 24'd0;
    endfunction

    // Cycle model: at each falling edge, compare what the DUT shows now, then
    // work out what the coming rising edge does.
    always @(negedge clock) begin
        if (!resetN) begin
            model_reset();
            check_output("resetrt_in_reset", 32'(resetRT), 32'd1);
            check_output("smvalid_in_reset", 32'(smValid), 32'd0);
        end else begin
            logic       taken;
            logic [NC-1:0] ev, clr;
            int         off, c;
            bit         cnt_clr;
            check_output("start", 32'(start), 32'(exp_start));
            check_output("flush", 32'(flush), 32'(exp_flush));
            check_output("reset_rt", 32'(resetRT), 32'(exp_reset_rt));
            check_output("interrupt", 32'(interrupt), 32'(exp_int));
            check_output("normalize", 32'(normalize), 32'(m_norm));
            check_output("sm_valid", 32'(smValid), 32'(m_resp));
            check_output("material", materialAddress, {m_addr[0], 8'h00});
            check_output("tree", treeAddress, {m_addr[1], 8'h00});
            check_output("frame", frameAddress, {m_addr[2], 8'h00});
            for (int i = 0; i < 3; i++) begin
                check_output("camera_q", 32'(cameraQ[i]), 32'(m_cam[i]));
                check_output("camera_v", 32'({cameraV[i]}), 32'(m_cam[3+i]));
                check_output("camera_x", 32'({cameraX[i]}), 32'(m_cam[6+i]));
                check_output("camera_y", 32'({cameraY[i]}), 32'(m_cam[9+i]));
            end
            check_output("width", 32'(width), 32'(m_width));
            check_output("height", 32'(height), 32'(m_height));
            for (int k = 0; k < NC; k++) begin
                check_output("row_start", 32'(rowStart[k]), 32'(m_row_s[k]));
                check_output("row_end", 32'(rowEnd[k]), 32'(m_row_e[k]));
            end

            taken = msValid && (msAddress[31:6] == 26'd0) && (!m_resp || smTaken);
            check_output("ms_taken", 32'(msTaken), 32'(taken));
            off = int'(msAddress[5:0]);
            exp_int = |(m_status & m_mask);
            exp_start = '0; exp_flush = 1'b0; exp_reset_rt = 1'b0;
            ev = m_prev_busy & ~busy;
            clr = '0; cnt_clr = 1'b0;
            if (taken && !msWrite) exp_q.push_back('{data: read_value(off), id: msID});
            if (taken && msWrite) begin
                if (off == 0) begin
                    if (msData[0]) exp_start = m_enable;
                    exp_flush = msData[3];
                    exp_reset_rt = msData[4];
                    m_norm = msData[5];
                end else if (off <= 3) m_addr[off-1] = msData;
                else if (off <= 15) m_cam[off-4] = msData[15:0];
                else if (off == 16) m_width = msData[11:0];
                else if (off == 17) m_height = msData[11:0];
                else if (off == 18) m_enable = msData[NC-1:0];
                else if (off == 19) clr = msData[NC-1:0];
                else if (off == 20) m_mask = msData[NC-1:0];
                else if (off == 21) cnt_clr = 1'b1;
                else if (off >= 32) begin
                    c = (off - 32) / 2;
                    if (c < NC && off % 2 == 0) begin
                        m_row_s[c] = msData[11:0];
                        m_row_e[c] = msData[23:12];
                    end else if (c < NC && msData[0]) exp_start[c] = 1'b1;
                end
            end
            if (taken && !msWrite) m_resp = 1'b1;
            else if (smTaken) m_resp = 1'b0;
            m_status = (m_status & ~clr) | ev;
            if (cnt_clr) m_count = 0;
            m_count = m_count + $countones(ev);
            if (m_count > 24'hFFFFFF) m_count = 24'hFFFFFF;
            m_prev_busy = busy;
        end
    end

    // Response monitor: pops the scoreboard whenever a response is handed over.
    logic        prev_hold = 1'b0;
    logic [23:0] prev_data;
    logic [3:0]  prev_id;
    always @(negedge clock) begin
        if (!resetN) prev_hold = 1'b0;
        else begin
            resp_t e;
            if (prev_hold) check_output("resp_stable", {4'd0, smID, smData}, {4'd0, prev_id, prev_data});
            if (smValid && smTaken) begin
                if (exp_q.size() == 0) check_output("resp_unexpected", 32'd0, 32'd1);
                else begin
                    e = exp_q.pop_front();
                    check_output("resp_data", 32'(smData), 32'(e.data));
                    check_output("resp_id", 32'(smID), 32'(e.id));
                end
            end
            prev_hold = smValid && !smTaken;
            prev_data = smData;
            prev_id   = smID;
        end
    end

    always @(posedge clock) begin
        if (rand_taken) begin
            #1;
            smTaken = 1'($urandom_range(0, 1));
        end
    end

    task automatic apply_stimulus(input bit write, input int off, input logic [23:0] data, input bit miss);
        int waited = 0;
        msValid   = 1'b1;
        msWrite   = write;
        msAddress = {miss ? 26'h1 : 26'h0, 6'(off)};
        msData    = data;
        msID      = next_id;
        next_id   = next_id + 4'd1;
        if (miss) begin
            repeat (2) @(posedge clock);
            #1;
        end else begin
            @(negedge clock);
            while (!msTaken && waited < 50) begin
                waited++;
                @(negedge clock);
            end
            if (!msTaken) check_output("accept_timeout", 32'(msTaken), 32'd1);
            @(posedge clock);
            #1;
        end
        msValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        resetN = 1'b0; msValid = 1'b0; msWrite = 1'b0; msAddress = '0;
        msData = '0; msID = '0; smTaken = 1'b1; ready = 4'hF; busy = 4'h0;
        repeat (3) @(posedge clock);
        #2 resetN = 1'b1;
        idle(2);

        apply_stimulus(0, 8'h12, 0, 0);
        apply_stimulus(0, 8'h00, 0, 0);
        apply_stimulus(1, 8'h04, 24'h012345, 0);
        apply_stimulus(0, 8'h04, 0, 0);
        apply_stimulus(1, 8'h07, 24'h00FFFF, 0);
        apply_stimulus(0, 8'h07, 0, 0);
        idle(1);
        check_output("camera_v0_neg", 32'({cameraV[0]}), 32'h0000FFFF);

        apply_stimulus(1, 8'h12, 24'h5, 0);
        apply_stimulus(1, 8'h00, 24'h1, 0);
        idle(2);
        apply_stimulus(1, 8'h23, 24'h1, 0);
        idle(2);

        apply_stimulus(1, 8'h14, 24'h5, 0);
        busy = 4'hF;
        idle(2);
        busy = 4'b1010;
        idle(3);
        apply_stimulus(0, 8'h13, 0, 0);
        apply_stimulus(0, 8'h15, 0, 0);
        busy = 4'b1011;
        idle(1);
        busy = 4'b1010;
        apply_stimulus(1, 8'h13, 24'h1, 0);
        apply_stimulus(0, 8'h13, 0, 0);

        for (int i = 0; i < 4; i++) apply_stimulus(0, 8'h20 + 2 * i, 0, 0);
        idle(1);
        smTaken = 1'b0;
        fork
            begin
                apply_stimulus(0, 8'h10, 0, 0);
                apply_stimulus(0, 8'h11, 0, 0);
            end
            begin
                repeat (4) @(posedge clock);
                #1 smTaken = 1'b1;
            end
        join
        idle(2);

        apply_stimulus(0, 8'h3F, 0, 0);
        apply_stimulus(0, 8'h2A, 0, 0);
        apply_stimulus(1, 8'h3F, 24'hFFFFFF, 0);
        apply_stimulus(1, 8'h01, 24'hABCDEF, 1);
        apply_stimulus(1, 8'h10, 24'h000123, 0);

        smTaken = 1'b0;
        apply_stimulus(0, 8'h10, 0, 0);
        check_output("resp_pending", 32'(smValid), 32'd1);
        #1 resetN = 1'b0;
        #1 check_output("smvalid_dropped", 32'(smValid), 32'd0);
        repeat (2) @(posedge clock);
        #2 resetN = 1'b1;
        smTaken = 1'b1;
        idle(1);
        apply_stimulus(0, 8'h12, 0, 0);
        apply_stimulus(0, 8'h04, 0, 0);

        rand_taken = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int  off;
            if ($urandom_range(0, 3) == 0) busy = 4'($urandom);
            ready = 4'($urandom);
            off = $urandom_range(0, 1) ? $urandom_range(0, 21) : $urandom_range(0, 63);
            apply_stimulus(1'($urandom_range(0, 1)), off, 24'($urandom),
                           $urandom_range(0, 19) == 0);
        end
        rand_taken = 1'b0;
        @(posedge clock);
        #2 smTaken = 1'b1;
        idle(4);
        check_output("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
